// File: rtl/bcd_stream_conv.sv
// -----------------------------------------------------------------------------
// bcd_stream_conv
//
// Streaming binary-to-BCD converter. It sits between a value generator and the
// seven-segment digit decoders. It takes one unsigned value per handshake and
// converts it with an iterative shift-and-add-3 (double-dabble) engine, one
// input bit per clock. It then holds six BCD digits, a per-digit leading-zero
// blank mask and an overflow flag until the consumer takes them. The
// generator's end-of-stream is forwarded once no value is pending.
//
// Parameters
//   WIDTH   input value width (1..32); also the number of conversion cycles
//   DIGITS  BCD digits presented on the output (6, one per HEX display)
//
// Ports
//   __clock        in   rising-edge clock
//   __reset        in   synchronous active-high reset, highest priority
//   __input_0      in   [WIDTH]     unsigned value from the generator
//   __input_valid  in   generator value valid
//   __input_ready  out  converter can accept a value (IDLE only)
//   __input_done   in   generator end-of-stream
//   __output_0     out  [4*DIGITS]  digit i on bits [4i+3:4i], digit 0 = LSD
//   __blank        out  [DIGITS]    bit i set when digit i is a leading zero
//   __overflow     out  value >= 10**DIGITS
//   __valid        out  output word valid (HOLD only)
//   __ready        in   consumer accepts the output word
//   __done         out  stream ended and nothing is pending
// -----------------------------------------------------------------------------
module bcd_stream_conv #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 6
) (
    input  logic                  __clock,
    input  logic                  __reset,
    input  logic [WIDTH-1:0]      __input_0,
    input  logic                  __input_valid,
    output logic                  __input_ready,
    input  logic                  __input_done,
    output logic [4*DIGITS-1:0]   __output_0,
    output logic [DIGITS-1:0]     __blank,
    output logic                  __overflow,
    output logic                  __valid,
    input  logic                  __ready,
    output logic                  __done
);

    // Ten BCD digits hold any 32-bit value (max 4294967295).
    localparam int ACC_DIGITS = 10;
    localparam int ACC_BITS   = 4 * ACC_DIGITS;
    localparam int OUT_BITS   = 4 * DIGITS;
    localparam logic [5:0] CNT_INIT = 6'(WIDTH);

    // Digit pattern shown by a converted zero: only digit 0 lit.
    localparam logic [DIGITS-1:0] BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        HOLD
    } state_t;

    state_t                 state;
    logic [ACC_BITS-1:0]    acc;
    logic [WIDTH-1:0]       sr;
    logic [5:0]             cnt;
    logic                   src_done;

    logic                   ready_r;
    logic                   valid_r;
    logic [OUT_BITS-1:0]    digits_r;
    logic [DIGITS-1:0]      blank_r;
    logic                   overflow_r;

    // Next-step datapath values for one double-dabble iteration.
    logic [ACC_BITS-1:0]    acc_adj;
    logic [ACC_BITS-1:0]    acc_shift;
    logic [WIDTH-1:0]       sr_shift;

    // Output decode of the accumulator after the step in flight; only
    // registered on the final conversion cycle.
    logic [OUT_BITS-1:0]    digits_next;
    logic                   overflow_next;
    logic [DIGITS-1:0]      blank_next;
    logic                   upper_zero;

    // -------------------------------------------------------------------------
    // Double-dabble step: every digit >= 5 gets +3 (all in parallel), then the
    // concatenation {acc, sr} shifts left one bit, pulling the next input bit
    // (MSB first) into BCD digit 0.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned; otherwise a latch is inferred.
        acc_adj = acc;
        for (int d = 0; d < ACC_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_adj[ACC_BITS-2:0], sr[WIDTH-1]};
        sr_shift  = sr << 1;
    end

    // -------------------------------------------------------------------------
    // Output decode. Overflow covers any nonzero digit above the displayed
    // ones. A digit is blanked when it and every digit above it are zero. A
    // value that overflows shows all six low digits, so no digit is blanked.
    // Digit 0 is never blanked, so a zero value still shows "0".
    // -------------------------------------------------------------------------
    always_comb begin
        digits_next   = acc_shift[OUT_BITS-1:0];
        overflow_next = |acc_shift[ACC_BITS-1:OUT_BITS];
        blank_next    = '0;
        upper_zero    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero    = upper_zero && (digits_next[4*i +: 4] == 4'd0);
            blank_next[i] = upper_zero && !overflow_next;
        end
        blank_next[0] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake outputs. Ready is high exactly in
    // IDLE and valid exactly in HOLD, so the two are never high together.
    // -------------------------------------------------------------------------
    always_ff @(posedge __clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the edge regardless of order.
        if (__reset) begin
            state      <= IDLE;
            acc        <= '0;
            sr         <= '0;
            cnt        <= '0;
            src_done   <= 1'b0;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            digits_r   <= '0;
            blank_r    <= BLANK_ZERO;
            overflow_r <= 1'b0;
        end else begin
            // End-of-stream is sticky; it may arrive in any state.
            if (__input_done) begin
                src_done <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // ready_r is high throughout IDLE, so valid alone is the
                    // handshake.
                    if (__input_valid) begin
                        sr      <= __input_0;
                        acc     <= '0;
                        cnt     <= CNT_INIT;
                        ready_r <= 1'b0;
                        state   <= CONVERT;
                    end
                end

                CONVERT: begin
                    acc <= acc_shift;
                    sr  <= sr_shift;
                    cnt <= cnt - 6'd1;
                    // Last input bit is being shifted in: capture the decode
                    // of the final accumulator in the same edge.
                    if (cnt == 6'd1) begin
                        digits_r   <= digits_next;
                        blank_r    <= blank_next;
                        overflow_r <= overflow_next;
                        valid_r    <= 1'b1;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    // No skid buffer: new input waits until IDLE.
                    if (__ready) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign __input_ready = ready_r;
    assign __valid       = valid_r;
    assign __output_0    = digits_r;
    assign __blank       = blank_r;
    assign __overflow    = overflow_r;

    // A value offered alongside end-of-stream is still pending, so done waits
    // until the FSM is idle with nothing offered.
    assign __done = src_done && (state == IDLE) && !__input_valid;

endmodule

// File: tb/tb_bcd_stream_conv.sv
// -----------------------------------------------------------------------------
// tb_bcd_stream_conv
//
// Directed bench for bcd_stream_conv (WIDTH=32, DIGITS=6). Inputs are driven
// 1 ns after the rising edge and outputs are sampled at the same point.
// Expected digits, blank masks and overflow flags are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_bcd_stream_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in0 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_done = 1'b0;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic        ovf;
    logic        valid;
    logic        out_ready = 1'b1;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bcd_stream_conv #(.WIDTH(32), .DIGITS(6)) dut (
        .__clock       (clk),
        .__reset       (rst),
        .__input_0     (in0),
        .__input_valid (in_valid),
        .__input_ready (in_ready),
        .__input_done  (in_done),
        .__output_0    (digits),
        .__blank       (blank),
        .__overflow    (ovf),
        .__valid       (valid),
        .__ready       (out_ready),
        .__done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one value (optionally with end-of-stream), check latency and the
    // result, then let the consumer take it. vcyc is the cycle valid was seen.
    task automatic convert_one(input string tag, input logic [31:0] v,
                               input logic [23:0] exp_d, input logic [5:0] exp_b,
                               input logic exp_o, input logic fin, output int vcyc);
        int n;
        check({tag, "_in_ready"}, in_ready, 1);
        in0      = v;
        in_valid = 1'b1;
        in_done  = fin;
        #1;
        if (fin) check({tag, "_done_with_value"}, done, 0);
        step();
        in_valid = 1'b0;
        in_done  = 1'b0;
        in0      = '0;
        n = 0;
        while (valid !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        vcyc = cyc;
        check({tag, "_latency"}, n, 32);
        check({tag, "_digits"}, digits, exp_d);
        check({tag, "_blank"}, blank, exp_b);
        check({tag, "_overflow"}, ovf, exp_o);
        check({tag, "_ready_low_in_hold"}, in_ready, 0);
        check({tag, "_done_in_hold"}, done, 0);
        step();
        check({tag, "_valid_after_take"}, valid, 0);
        check({tag, "_ready_after_take"}, in_ready, 1);
        check({tag, "_done_after_take"}, done, fin);
    endtask

    typedef struct {
        logic [31:0] v;
        logic [23:0] d;
        logic [5:0]  b;
    } vec_t;

    initial begin
        int vc;
        int prev;
        int n;
        int hi;
        vec_t stream [6];

        // ---------------- reset ----------------
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_digits", digits, 24'h0);
        check("rst_blank", blank, 6'b111110);
        check("rst_overflow", ovf, 0);
        check("rst_valid", valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_done", done, 0);

        // ---------------- single conversions ----------------
        convert_one("v100", 32'd100, 24'h000100, 6'b111000, 1'b0, 1'b0, vc);
        convert_one("v0", 32'd0, 24'h000000, 6'b111110, 1'b0, 1'b0, vc);
        convert_one("v999999", 32'd999999, 24'h999999, 6'b000000, 1'b0, 1'b0, vc);
        convert_one("v1000000", 32'd1000000, 24'h000000, 6'b000000, 1'b1, 1'b0, vc);
        convert_one("vmax", 32'hFFFF_FFFF, 24'h967295, 6'b000000, 1'b1, 1'b0, vc);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in0       = 32'd12345;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("bp_latency", n, 32);
        in0      = 32'd777;
        in_valid = 1'b1;
        repeat (10) begin
            step();
            check("bp_valid", valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_digits", digits, 24'h012345);
            check("bp_blank", blank, 6'b100000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", valid, 0);
        check("bp_release_ready", in_ready, 1);
        convert_one("bp_next", 32'd42, 24'h000042, 6'b111100, 1'b0, 1'b0, vc);

        // ---------------- back-to-back stream, done on last ----------------
        stream[0] = '{32'd1, 24'h000001, 6'b111110};
        stream[1] = '{32'd1, 24'h000001, 6'b111110};
        stream[2] = '{32'd2, 24'h000002, 6'b111110};
        stream[3] = '{32'd3, 24'h000003, 6'b111110};
        stream[4] = '{32'd5, 24'h000005, 6'b111110};
        stream[5] = '{32'd8, 24'h000008, 6'b111110};
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            convert_one($sformatf("fib%0d", k), stream[k].v, stream[k].d,
                        stream[k].b, 1'b0, (k == 5), vc);
            if (k > 0) check($sformatf("fib%0d_spacing", k), vc - prev, 34);
            prev = vc;
        end
        step();
        check("done_sticky", done, 1);

        // ---------------- reset mid-conversion ----------------
        in0      = 32'd555;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_blank", blank, 6'b111110);
        hi = 0;
        repeat (40) begin
            step();
            if (valid) hi++;
        end
        check("midrst_no_valid", hi, 0);
        convert_one("midrst_next", 32'd4321, 24'h004321, 6'b110000, 1'b0, 1'b0, vc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
